// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state encoding for the iterative arithmetic blocks
package arith_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
endpackage

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-add multiply-accumulate, product = multiplicand*multiplier + addend
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int P_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [P_WIDTH-1:0]     multiplicand_in,
  input  logic [P_WIDTH-1:0]     multiplier_in,
  input  logic [P_WIDTH-1:0]     addend_in,
  output logic [2*P_WIDTH-1:0]   product_out,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done
);
  localparam int CW = $clog2(P_WIDTH + 1);
  state_t state, state_nx;
  logic [P_WIDTH-1:0] mcand, mult, addend;
  logic [P_WIDTH:0] acc, sum;
  logic [CW-1:0] cnt;
  logic [2*P_WIDTH-1:0] result;
  logic accept, last;
  assign accept = (state == IDLE) && start;
  assign last = (state == CALC) && (cnt == CW'(1));
  // result is the final shift of {sum, mult} plus the zero-extended addend
  always_comb begin
    sum = acc + {1'b0, (mult[0] ? mcand : '0)};
    result = {sum, mult[P_WIDTH-1:1]} + {{P_WIDTH{1'b0}}, addend};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = accept ? CALC : last ? FINISH : (state == FINISH) ? IDLE : state;
  always_comb begin
    busy = state != IDLE;
    done = state == FINISH;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      mult <= '0;
      addend <= '0;
      acc <= '0;
      cnt <= '0;
      product_out <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      mcand <= multiplicand_in;
      mult <= multiplier_in;
      addend <= addend_in;
      acc <= '0;
      cnt <= CW'(P_WIDTH);
      product_out <= '0;
      overflow <= 1'b0;
    end else if (state == CALC) begin
      acc <= {1'b0, sum[P_WIDTH:1]};
      mult <= {sum[0], mult[P_WIDTH-1:1]};
      cnt <= cnt - 1'b1;
      if (last) begin
        product_out <= result;
        overflow <= |result[2*P_WIDTH-1:P_WIDTH];
      end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed vector table plus multi-cycle corner sequences
module tb_shift_add_multiplier;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic [2*W-1:0] product_out;
  logic overflow, busy, done;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.P_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand_in(a), .multiplier_in(b), .addend_in(c),
    .product_out(product_out), .overflow(overflow), .busy(busy), .done(done)
  );

  typedef struct {
    logic [W-1:0] a, b, c;
    logic [2*W-1:0] p;
    logic o;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    a = x; b = y; c = z; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~x; b = ~y; c = ~z;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!done && edges < 100);
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int e, n, t1, t2;
    logic [2*W-1:0] p1, p2;
    vecs[0] = '{32'd7, 32'd6, 32'd0, 64'd42, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b1};
    vecs[2] = '{32'h10, 32'h12345, 32'hF, 64'h12_345F, 1'b0};
    vecs[3] = '{32'h0, 32'hABCD, 32'h5, 64'd5, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'd2, 32'd0, 64'h1_0000_0000, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 64'h1_FFFF_FFFE, 1'b1};
    #12;
    check("rst_product", product_out, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].c);
      wait_done(e);
      check($sformatf("v%0d_latency", i), 64'(e + 1), 64'd33);
      check($sformatf("v%0d_product", i), product_out, vecs[i].p);
      check($sformatf("v%0d_overflow", i), {63'd0, overflow}, {63'd0, vecs[i].o});
      check($sformatf("v%0d_busy", i), {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
      check($sformatf("v%0d_hold", i), product_out, vecs[i].p);
      check($sformatf("v%0d_idle", i), {63'd0, busy}, 64'd0);
    end
    // start pulse mid-CALC must be ignored
    launch(32'd7, 32'd6, 32'd0);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; a = 32'd3; b = 32'd3; c = 32'd1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; p1 = '0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      if (done) begin n++; p1 = product_out; end
    end
    check("midcalc_done_count", 64'(n), 64'd1);
    check("midcalc_product", p1, 64'd42);
    // reset asserted during CALC aborts with no done
    launch(32'hFFFF_FFFF, 32'd2, 32'd0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_product", product_out, 64'd0);
    check("abort_overflow", {63'd0, overflow}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    start = 1'b1; a = 32'd9; b = 32'd9; c = 32'd1;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done || busy) n++;
    end
    check("abort_quiet", 64'(n), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("post_rst_accept", {63'd0, busy}, 64'd1);
    wait_done(e);
    check("post_rst_latency", 64'(e + 1), 64'd33);
    check("post_rst_product", product_out, 64'd82);
    @(posedge clk); #1;
    // start held high: back-to-back operations
    a = 32'd7; b = 32'd6; c = 32'd0; start = 1'b1;
    n = 0; t1 = 0; t2 = 0; p1 = '0; p2 = '0;
    for (int k = 1; k <= 120 && n < 2; k++) begin
      @(posedge clk); #1;
      if (done) begin
        n++;
        if (n == 1) begin t1 = k; p1 = product_out; a = 32'd5; b = 32'd5; c = 32'd3; end
        else begin t2 = k; p2 = product_out; start = 1'b0; end
      end
    end
    start = 1'b0;
    check("b2b_count", 64'(n), 64'd2);
    check("b2b_spacing", 64'(t2 - t1), 64'd34);
    check("b2b_product1", p1, 64'd42);
    check("b2b_product2", p2, 64'd28);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
